engine_sched_ctrl: RTL and testbench
====================================

# engine_sched_ctrl

Round-robin scheduler that shares one enable/done processing engine (the `top` datapath: `enable` in, `done_qo` out) among N_REQ requesters. It grants the engine to one requester at a time, drives the engine enable for the job, and returns a one-cycle done or error pulse to the owner. A watchdog aborts jobs whose engine never signals done. It sits between requester logic and a single engine instance in the same clock domain.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 1000, max cycles in RUN before abort (≥2)
- GAP_CYC, 2, minimum enable-low cycles between jobs (≥1)
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req  in  N_REQ  per-requester job request, level
- grant  out  N_REQ  one-hot owner of engine, 0 when none
- done_o  out  N_REQ  one-cycle pulse to owner on job completion
- err_o  out  N_REQ  one-cycle pulse to owner on timeout abort
- engine_en  out  1  drives engine `enable`
- engine_done  in  1  engine `done_qo`
- busy  out  1  high in any state except IDLE
- err_cnt  out  8  saturating count of aborts

## Operation
- States: IDLE, ARB, RUN, DONE, ABORT, GAP.
- IDLE: engine_en=0, grant=0. Any req bit high → ARB.
- ARB (1 cycle): pick first set req bit searching from ptr+1 upward, wrapping mod N_REQ; register grant one-hot → RUN. If req fell to 0 meanwhile → IDLE, grant stays 0.
- RUN: engine_en=1, grant held, wdog counts from 0. engine_done=1 → DONE. wdog==TIMEOUT-1 with engine_done=0 → ABORT. Done wins if both occur in the same cycle.
- DONE (1 cycle): engine_en=0, done_o=grant, ptr←granted index → GAP.
- ABORT (1 cycle): engine_en=0, err_o=grant, err_cnt+1 (saturates at 255), ptr←granted index → GAP.
- GAP: engine_en=0, grant=0. Stay ≥GAP_CYC cycles, and remain while engine_done=1. Then → IDLE.
- Owner's req dropping during RUN is ignored; the job runs to DONE/ABORT. A req still high after done_o is a new job at lowest priority.
- ptr reset value N_REQ-1, giving req[0] first priority.
- engine_done is ignored outside RUN.
- Reset (any state, async): all outputs 0, state IDLE, ptr=N_REQ-1, wdog=0, GAP counter=0. An in-flight job ends silently with no done_o or err_o pulse.

## Timing
- All outputs registered. Outputs change only on rising clk, except async reset clear.
- req sampled high at edge k (IDLE) → ARB after k → grant and engine_en high after k+1. Request-to-enable latency is 2 cycles.
- engine_done high sampled at edge m → engine_en low and done_o pulse after m, both for exactly one cycle.
- Timeout: engine_en high for exactly TIMEOUT cycles, then err_o pulse.
- Minimum job-to-job turnaround, done to next engine_en: 1 (DONE) + GAP_CYC + 1 (IDLE) + 1 (ARB) cycles = 5 at defaults.
- grant, done_o and err_o are always one-hot or zero. done_o and err_o are never both nonzero.

## Test plan
- Single job: req=0001, engine_done pulses 20 cycles after engine_en rises → grant=0001 two cycles after req; done_o=0001 for 1 cycle; engine_en low for ≥2 cycles; err_cnt=0.
- Contention: req=1111 held, engine done after 5 cycles each → grant order 0001,0010,0100,1000,0001; exactly one done_o pulse per job.
- Timeout: TIMEOUT=16, req=0100, engine_done held 0 → engine_en high exactly 16 cycles; err_o=0100 pulse; err_cnt=1; next grant goes to another pending requester before req[2].
- Done/timeout tie: engine_done first rises in the cycle where wdog==TIMEOUT-1 → done_o pulses, no err_o, err_cnt unchanged.
- Stuck done: engine_done held high through GAP for 10 cycles → state stays in GAP and busy=1 until done falls, then IDLE; no extra done_o pulse.
- Reset mid-RUN: rst=0 for 1 cycle during a job → grant, engine_en, done_o, err_o, busy all 0 immediately; err_cnt=0; after release, req=0010 is served first-come with ptr reset, so req[0] wins if req=0011.

Source files
------------

// File: rtl/engine_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : engine_sched_ctrl
//  Purpose  : Round-robin scheduler sharing one enable/done engine among
//             N_REQ requesters, with a per-job watchdog and an enforced
//             enable-low gap between consecutive jobs.
//  Revision : 1.0  initial release
// ============================================================================
module engine_sched_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1000,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done_o,
    output logic [N_REQ-1:0] err_o,
    output logic             engine_en,
    input  logic             engine_done,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Watchdog only needs to reach TIMEOUT-1, gap counter only GAP_CYC-1.
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GP_W-1:0]  C_GAP_LAST = GP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] C_PTR_RST  = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] C_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [GP_W-1:0]    gap_q, gap_d;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand_idx;

    // Round-robin pick: first set request bit at ptr+1, ptr+2, ... wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered from *_d.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        err_cnt_d = err_cnt_q;
        done_d    = '0;
        err_d     = '0;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (arb_found) begin
                    state_d = S_RUN;
                    gidx_d  = arb_idx;
                    grant_d = C_ONE << arb_idx;
                    wdog_d  = '0;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_RUN: begin
                // Done takes priority over a watchdog expiry in the same cycle.
                if (engine_done) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    ptr_d   = gidx_q;
                end else if (wdog_q == C_WD_LAST) begin
                    state_d = S_ABORT;
                    err_d   = grant_q;
                    ptr_d   = gidx_q;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_DONE, S_ABORT: begin
                state_d = S_GAP;
                grant_d = '0;
                gap_d   = '0;
            end
            S_GAP: begin
                // Leave only after the minimum gap and once the engine has
                // dropped done, so a stuck done cannot start the next job.
                if (gap_q == C_GAP_LAST) begin
                    if (!engine_done) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        en_d   = (state_d == S_RUN);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= C_PTR_RST;
            gidx_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= 8'd0;
            wdog_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
        end
    end

    assign grant     = grant_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign engine_en = en_q;
    assign busy      = busy_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_engine_sched_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_engine_sched_ctrl
//  Purpose  : Self-checking bench for engine_sched_ctrl. The bench plays the
//             engine and checks each job against a job-level reference model
//             (round-robin pick, expected enable length, gap length).
//  Revision : 1.0  initial release
// ============================================================================
module tb_engine_sched_ctrl;

    localparam int N = 4;
    localparam int T = 16;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic         engine_done = 1'b0;
    logic [N-1:0] grant;
    logic [N-1:0] done_o;
    logic [N-1:0] err_o;
    logic         engine_en;
    logic         busy;
    logic [7:0]   err_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int ptr_m   = N - 1;
    int exp_err = 0;

    // Observations captured by the job driver
    logic [N-1:0] obs_g, obs_d, obs_e, obs_d2, obs_e2;
    logic         obs_en_g;
    int           obs_lat, obs_n, obs_k, obs_extra;

    engine_sched_ctrl #(
        .N_REQ   (N),
        .TIMEOUT (T),
        .GAP_CYC (G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .done_o      (done_o),
        .err_o       (err_o),
        .engine_en   (engine_en),
        .engine_done (engine_done),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit after position p, wrapping.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] res;
        res = '0;
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (p + i) % N;
            if (res == '0 && r[j]) res = N'(1 << j);
        end
        return res;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < N; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    // Drive one job from IDLE: raise req, act as engine (done after lat
    // enable cycles, held for hold cycles), then wait for the scheduler idle.
    task automatic run_job(input logic [N-1:0] r, input int lat, input int hold, input bit drop);
        int n, dl, k;
        req = r;
        obs_lat = 0;
        while (grant == '0 && obs_lat < 10) begin
            tick();
            obs_lat++;
        end
        obs_g    = grant;
        obs_en_g = engine_en;
        n  = 0;
        dl = 0;
        if (obs_g != '0) begin
            while (engine_en === 1'b1 && n < 200) begin
                n++;
                if (n == lat) dl = hold;
                engine_done = (dl > 0);
                if (drop && n == 1) req = N'($urandom);
                tick();
                if (dl > 0) dl--;
            end
        end
        obs_n = n;
        obs_d = done_o;
        obs_e = err_o;
        engine_done = (dl > 0);
        tick();
        if (dl > 0) dl--;
        obs_d2    = done_o;
        obs_e2    = err_o;
        obs_extra = 0;
        k = 0;
        while (busy === 1'b1 && k < 60) begin
            engine_done = (dl > 0);
            tick();
            if (dl > 0) dl--;
            k++;
            if (done_o != '0 || err_o != '0) obs_extra++;
        end
        engine_done = 1'b0;
        obs_k = (busy === 1'b1) ? -1 : k;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        checks++;
        if ({grant, done_o, err_o, engine_en, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b done=%b err=%b en=%b busy=%b required all 0",
                     grant, done_o, err_o, engine_en, busy);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
        rst = 1'b1;
        ptr_m   = N - 1;
        exp_err = 0;
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, 5, 1, 1'b0);
            checks++;
            if (obs_g !== seq[j]) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b required %b", j, obs_g, seq[j]);
            end
            checks++;
            if (obs_d !== seq[j] || obs_d2 !== '0 || obs_extra != 0) begin
                errors++;
                $display("FAIL contention_done[%0d]: got %b then %b extra=%0d required %b then 0000",
                         j, obs_d, obs_d2, obs_extra, seq[j]);
            end
        end
        req   = '0;
        ptr_m = 0;
    endtask

    task automatic test_single();
        run_job(4'b0001, 12, 1, 1'b0);
        req   = '0;
        ptr_m = 0;
        checks++;
        if (obs_g !== 4'b0001 || obs_lat != 2 || obs_en_g !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got %b latency=%0d en=%b required 0001 latency=2 en=1",
                     obs_g, obs_lat, obs_en_g);
        end
        checks++;
        if (obs_n != 12) begin
            errors++;
            $display("FAIL single_en_len: got %0d required 12", obs_n);
        end
        checks++;
        if (obs_d !== 4'b0001 || obs_e !== '0 || obs_d2 !== '0) begin
            errors++;
            $display("FAIL single_done: got done=%b err=%b next=%b required 0001 0000 0000",
                     obs_d, obs_e, obs_d2);
        end
        checks++;
        if (obs_k != G) begin
            errors++;
            $display("FAIL single_gap: got %0d required %0d", obs_k, G);
        end
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL single_err_cnt: got %0d required %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_timeout();
        run_job(4'b0100, 1000, 1, 1'b0);
        ptr_m = 2;
        exp_err++;
        checks++;
        if (obs_n != T) begin
            errors++;
            $display("FAIL timeout_en_len: got %0d required %0d", obs_n, T);
        end
        checks++;
        if (obs_e !== 4'b0100 || obs_d !== '0 || obs_e2 !== '0) begin
            errors++;
            $display("FAIL timeout_err: got err=%b done=%b next=%b required 0100 0000 0000",
                     obs_e, obs_d, obs_e2);
        end
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL timeout_err_cnt: got %0d required %0d", err_cnt, exp_err);
        end
        run_job(4'b0101, 4, 1, 1'b0);
        req   = '0;
        ptr_m = 0;
        checks++;
        if (obs_g !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_next_grant: got %b required 0001", obs_g);
        end
    endtask

    task automatic test_tie();
        run_job(4'b1000, T, 1, 1'b0);
        req   = '0;
        ptr_m = 3;
        checks++;
        if (obs_d !== 4'b1000 || obs_e !== '0 || obs_n != T) begin
            errors++;
            $display("FAIL tie_done: got done=%b err=%b en_len=%0d required 1000 0000 %0d",
                     obs_d, obs_e, obs_n, T);
        end
        checks++;
        if (err_cnt !== 8'(exp_err)) begin
            errors++;
            $display("FAIL tie_err_cnt: got %0d required %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_stuck_done();
        run_job(4'b0010, 3, 12, 1'b0);
        req   = '0;
        ptr_m = 1;
        checks++;
        if (obs_k != 11) begin
            errors++;
            $display("FAIL stuck_gap_len: got %0d required 11", obs_k);
        end
        checks++;
        if (obs_d !== 4'b0010 || obs_d2 !== '0 || obs_extra != 0) begin
            errors++;
            $display("FAIL stuck_done_pulse: got %b then %b extra=%0d required 0010 then 0000 extra=0",
                     obs_d, obs_d2, obs_extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int w;
        req = 4'b0010;
        w = 0;
        while (grant == '0 && w < 10) begin
            tick();
            w++;
        end
        tick();
        tick();
        checks++;
        if (engine_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_running: got en=%b required 1", engine_en);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({grant, done_o, err_o, engine_en, busy} !== '0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_clear: got grant=%b done=%b err=%b en=%b busy=%b cnt=%0d required all 0",
                     grant, done_o, err_o, engine_en, busy, err_cnt);
        end
        req = '0;
        tick();
        rst = 1'b1;
        ptr_m   = N - 1;
        exp_err = 0;
        tick();
        run_job(4'b0011, 4, 1, 1'b0);
        req   = '0;
        ptr_m = 0;
        checks++;
        if (obs_g !== 4'b0001 || obs_lat != 2) begin
            errors++;
            $display("FAIL midrst_first_grant: got %b latency=%0d required 0001 latency=2", obs_g, obs_lat);
        end
        checks++;
        if (obs_d !== 4'b0001 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_job: got done=%b cnt=%0d required 0001 0", obs_d, err_cnt);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 40; j++) begin
            logic [N-1:0] r, exp_g;
            int lat, hold, eff_hold, exp_n, exp_k;
            bit drop, ok_done;
            r    = N'($urandom_range(1, 15));
            lat  = $urandom_range(1, 20);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : 1;
            drop = 1'($urandom_range(0, 1));
            exp_g    = rr_pick(r, ptr_m);
            ok_done  = (lat <= T);
            exp_n    = ok_done ? lat : T;
            eff_hold = ok_done ? hold : 0;
            exp_k    = (eff_hold - 1 > G) ? eff_hold - 1 : G;
            if (!ok_done && exp_err < 255) exp_err++;
            run_job(r, lat, hold, drop);
            ptr_m = oh2idx(exp_g);
            checks++;
            if (obs_g !== exp_g || obs_lat != 2) begin
                errors++;
                $display("FAIL rand_grant[%0d]: req=%b got %b latency=%0d required %b latency=2",
                         j, r, obs_g, obs_lat, exp_g);
            end
            checks++;
            if (obs_n != exp_n) begin
                errors++;
                $display("FAIL rand_en_len[%0d]: got %0d required %0d", j, obs_n, exp_n);
            end
            checks++;
            if (obs_d !== (ok_done ? exp_g : '0) || obs_e !== (ok_done ? '0 : exp_g)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got done=%b err=%b required done=%b err=%b",
                         j, obs_d, obs_e, ok_done ? exp_g : 4'b0, ok_done ? 4'b0 : exp_g);
            end
            checks++;
            if (obs_d2 !== '0 || obs_e2 !== '0 || obs_extra != 0) begin
                errors++;
                $display("FAIL rand_pulse_width[%0d]: got next done=%b err=%b extra=%0d required 0",
                         j, obs_d2, obs_e2, obs_extra);
            end
            checks++;
            if (obs_k != exp_k) begin
                errors++;
                $display("FAIL rand_gap[%0d]: got %0d required %0d", j, obs_k, exp_k);
            end
            checks++;
            if (err_cnt !== 8'(exp_err)) begin
                errors++;
                $display("FAIL rand_err_cnt[%0d]: got %0d required %0d", j, err_cnt, exp_err);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_tie();
        test_stuck_done();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
